// File: rtl/gpu_vga_scanout.sv
// gpu_vga_scanout
// VGA scan-out stage sitting behind the GPU pixel ROM. Divides the system
// clock down to the pixel rate, runs the horizontal/vertical raster counters,
// addresses a 256x256 RGB444 image window in the ROM and registers the
// returned pixel together with both syncs so colour and sync share one
// pixel period of latency.
module gpu_vga_scanout #(
    parameter int          CLK_DIV      = 4,
    parameter int          H_VISIBLE    = 640,
    parameter int          H_FP         = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BP         = 48,
    parameter int          V_VISIBLE    = 480,
    parameter int          V_FP         = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BP         = 33,
    parameter int          IMG_X0       = 192,
    parameter int          IMG_Y0       = 112,
    parameter logic [11:0] BORDER_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] rom_addr,
    output logic        rom_rd_en,
    input  logic [11:0] rom_data,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start
);

    // ------------------------------------------------------------------
    // Derived timing constants (all raster positions fit in 10 bits)
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [9:0] X_FIRST  = 10'(IMG_X0);
    localparam logic [9:0] X_LAST   = 10'(IMG_X0 + 255);
    localparam logic [9:0] Y_FIRST  = 10'(IMG_Y0);
    localparam logic [9:0] Y_LAST   = 10'(IMG_Y0 + 255);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             frame_start_q, frame_start_d;

    logic             tick;
    logic             line_end;
    logic             frame_end;
    logic             win;
    logic             visible;
    logic [7:0]       img_col;
    logic [7:0]       img_row;

    // Pixel-rate divider: tick marks the last system clock of a pixel period.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        div_cnt_d = div_cnt_q + DIV_W'(1);
        tick      = (div_cnt_q == DIV_LAST);
        if (tick) begin
            div_cnt_d = '0;
        end
    end

    // Raster counters: advance one pixel per tick, wrap line then frame.
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        line_end      = (h_cnt_q == H_LAST);
        frame_end     = line_end && (v_cnt_q == V_LAST);
        frame_start_d = tick && frame_end;
        if (tick) begin
            if (line_end) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // Stage 0: image-window decode and ROM address, straight off the counters.
    always_comb begin
        win       = (h_cnt_q >= X_FIRST) && (h_cnt_q <= X_LAST) &&
                    (v_cnt_q >= Y_FIRST) && (v_cnt_q <= Y_LAST);
        visible   = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        // Window offsets are taken modulo 256, so only the low bytes matter.
        img_col   = h_cnt_q[7:0] - X_FIRST[7:0];
        img_row   = v_cnt_q[7:0] - Y_FIRST[7:0];
        rom_rd_en = win;
        rom_addr  = win ? {img_row, img_col} : 16'h0000;
    end

    // Stage 1 next values: colour select and sync decode for the current pixel.
    always_comb begin
        if (win) begin
            rgb_d = rom_data;
        end else if (visible) begin
            rgb_d = BORDER_COLOR;
        end else begin
            rgb_d = 12'h000;
        end
        hs_d = ~((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vs_d = ~((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
    end

    // All state: synchronous reset, otherwise pixel registers update on tick only.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            rgb_q         <= 12'h000;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            // Single-cycle strobe: cleared on every non-wrap edge.
            frame_start_q <= frame_start_d;
            if (tick) begin
                rgb_q <= rgb_d;
                hs_q  <= hs_d;
                vs_q  <= vs_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_gpu_vga_scanout.sv
// tb_gpu_vga_scanout
// Two instances share one clock: u_dut0 uses the full 640x480 timing with a
// divide-by-4 pixel clock; u_dut1 uses divide-by-1, a red border and a raster
// just large enough to contain the whole 256x256 window, so window corners,
// vertical sync and frame wrap are all reached in a short run.
module tb_gpu_vga_scanout;

    typedef struct {
        int          clk_div;
        int          h_vis, h_fp, h_sync, h_bp;
        int          v_vis, v_fp, v_sync, v_bp;
        int          x0, y0;
        logic [11:0] border;
    } geom_t;

    typedef struct {
        logic [15:0] addr;
        logic        rd_en;
        logic [11:0] rgb;
        logic        hs, vs, fs;
    } exp_t;

    logic        clk;
    logic        rst0, rst1;
    logic [15:0] rom_addr0, rom_addr1;
    logic        rom_rd_en0, rom_rd_en1;
    logic [11:0] rom_data0, rom_data1;
    logic        vga_hs0, vga_hs1, vga_vs0, vga_vs1;
    logic [3:0]  vga_r0, vga_g0, vga_b0, vga_r1, vga_g1, vga_b1;
    logic        frame_start0, frame_start1;

    logic [11:0] rom_mem [0:65535];

    int    n_checks;
    int    n_errors;
    int    k0, k1;
    int    last_fall0;
    logic  prev_hs0;
    int    fs_count0, fs_count1;
    int    rst_at;
    geom_t g0, g1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM shared by both instances.
    assign rom_data0 = rom_mem[rom_addr0];
    assign rom_data1 = rom_mem[rom_addr1];

    gpu_vga_scanout u_dut0 (
        .clk         (clk),
        .rst         (rst0),
        .rom_addr    (rom_addr0),
        .rom_rd_en   (rom_rd_en0),
        .rom_data    (rom_data0),
        .vga_hs      (vga_hs0),
        .vga_vs      (vga_vs0),
        .vga_r       (vga_r0),
        .vga_g       (vga_g0),
        .vga_b       (vga_b0),
        .frame_start (frame_start0)
    );

    gpu_vga_scanout #(
        .CLK_DIV      (1),
        .H_VISIBLE    (255),
        .H_FP         (1),
        .H_SYNC       (1),
        .H_BP         (1),
        .V_VISIBLE    (255),
        .V_FP         (1),
        .V_SYNC       (1),
        .V_BP         (1),
        .IMG_X0       (1),
        .IMG_Y0       (1),
        .BORDER_COLOR (12'hF00)
    ) u_dut1 (
        .clk         (clk),
        .rst         (rst1),
        .rom_addr    (rom_addr1),
        .rom_rd_en   (rom_rd_en1),
        .rom_data    (rom_data1),
        .vga_hs      (vga_hs1),
        .vga_vs      (vga_vs1),
        .vga_r       (vga_r1),
        .vga_g       (vga_g1),
        .vga_b       (vga_b1),
        .frame_start (frame_start1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic in_window(input geom_t g, input int h, input int v);
        return (h >= g.x0) && (h < g.x0 + 256) && (v >= g.y0) && (v < g.y0 + 256);
    endfunction

    // Reference: after k system clocks out of reset the raster has advanced
    // k/CLK_DIV pixels; outputs show the previous pixel, stage 0 the current.
    function automatic exp_t model(input geom_t g, input int k);
        exp_t e;
        int   ht, vt, frame, p, cur, h, v, prv, ph, pv;
        ht    = g.h_vis + g.h_fp + g.h_sync + g.h_bp;
        vt    = g.v_vis + g.v_fp + g.v_sync + g.v_bp;
        frame = ht * vt;
        p     = k / g.clk_div;
        cur   = p % frame;
        h     = cur % ht;
        v     = cur / ht;
        e.rd_en = in_window(g, h, v);
        e.addr  = e.rd_en ? {8'(v - g.y0), 8'(h - g.x0)} : 16'h0000;
        e.fs    = (k % g.clk_div == 0) && (p > 0) && (cur == 0);
        if (p == 0) begin
            e.rgb = 12'h000;
            e.hs  = 1'b1;
            e.vs  = 1'b1;
        end else begin
            prv = (p - 1) % frame;
            ph  = prv % ht;
            pv  = prv / ht;
            if (in_window(g, ph, pv))
                e.rgb = rom_mem[{8'(pv - g.y0), 8'(ph - g.x0)}];
            else if (ph < g.h_vis && pv < g.v_vis)
                e.rgb = g.border;
            else
                e.rgb = 12'h000;
            e.hs = !(ph >= g.h_vis + g.h_fp && ph < g.h_vis + g.h_fp + g.h_sync);
            e.vs = !(pv >= g.v_vis + g.v_fp && pv < g.v_vis + g.v_fp + g.v_sync);
        end
        return e;
    endfunction

    task automatic compare(input string pfx, input exp_t e, input logic [15:0] addr,
                           input logic rd, input logic [11:0] rgb, input logic hs,
                           input logic vs, input logic fs);
        check({pfx, ".rom_addr"},    32'(addr), 32'(e.addr));
        check({pfx, ".rom_rd_en"},   32'(rd),   32'(e.rd_en));
        check({pfx, ".rgb"},         32'(rgb),  32'(e.rgb));
        check({pfx, ".vga_hs"},      32'(hs),   32'(e.hs));
        check({pfx, ".vga_vs"},      32'(vs),   32'(e.vs));
        check({pfx, ".frame_start"}, 32'(fs),   32'(e.fs));
    endtask

    // One system clock: note reset seen at the edge, then check on the falling edge.
    task automatic step();
        logic r0, r1;
        @(posedge clk);
        r0 = rst0;
        r1 = rst1;
        @(negedge clk);
        k0 = r0 ? 0 : k0 + 1;
        k1 = r1 ? 0 : k1 + 1;
        compare("d0", model(g0, k0), rom_addr0, rom_rd_en0,
                {vga_r0, vga_g0, vga_b0}, vga_hs0, vga_vs0, frame_start0);
        compare("d1", model(g1, k1), rom_addr1, rom_rd_en1,
                {vga_r1, vga_g1, vga_b1}, vga_hs1, vga_vs1, frame_start1);
        if (frame_start0) fs_count0++;
        if (frame_start1) fs_count1++;
        // Line timing of the full-size instance, measured on hsync falling edges.
        if (r0) begin
            last_fall0 = -1;
        end else if (prev_hs0 && !vga_hs0) begin
            if (last_fall0 < 0)
                check("d0.hs_first_fall_clk", 32'(k0), 32'(657 * 4));
            else
                check("d0.line_period_clk", 32'(k0 - last_fall0), 32'(800 * 4));
            last_fall0 = k0;
        end
        prev_hs0 = vga_hs0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        k0         = 0;
        k1         = 0;
        last_fall0 = -1;
        prev_hs0   = 1'b1;
        fs_count0  = 0;
        fs_count1  = 0;
        g0 = '{clk_div: 4, h_vis: 640, h_fp: 16, h_sync: 96, h_bp: 48,
               v_vis: 480, v_fp: 10, v_sync: 2, v_bp: 33,
               x0: 192, y0: 112, border: 12'h000};
        g1 = '{clk_div: 1, h_vis: 255, h_fp: 1, h_sync: 1, h_bp: 1,
               v_vis: 255, v_fp: 1, v_sync: 1, v_bp: 1,
               x0: 1, y0: 1, border: 12'hF00};
        for (int i = 0; i < 65536; i++) rom_mem[i] = 12'($urandom);

        // Power-on reset of both instances.
        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (3) step();
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Free run, then a 10-clock reset of the full-size instance mid-frame.
        rst_at = 20000 + int'($urandom_range(0, 5000));
        repeat (rst_at) step();
        rst0 = 1'b1;
        repeat (10) step();
        rst0 = 1'b0;

        // Continue until the small instance has wrapped its frame once.
        repeat (66600 - rst_at - 10) step();

        check("d1.frame_pulses", 32'(fs_count1), 32'd1);
        check("d0.frame_pulses", 32'(fs_count0), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
